// File: rtl/ifetch_decode.sv
// Fetch/decode stage: asynchronous ROM and branch-LUT reads, branch/halt decode, run/done FSM.
// Optional macro IFETCH_PARITY_EN adds an even-parity bit per ROM word and a sticky parity_err output.
module ifetch_decode #(
    parameter int A        = 10,
    parameter int W        = 9,
    parameter int L        = 5,
    parameter     ROM_FILE = "machine_code.txt",
    parameter     LUT_FILE = "branch_lut.txt"
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [A-1:0]        pc,
    output logic [W-1:0]        instr,
    output logic                branch_en,
    output logic signed [A-3:0] offset,
    output logic                run,
    output logic                done,
    output logic [15:0]         instr_count
`ifdef IFETCH_PARITY_EN
    ,
    output logic                parity_err
`endif
);

`ifdef IFETCH_PARITY_EN
    localparam int RW = W + 1;
`else
    localparam int RW = W;
`endif

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    logic [RW-1:0] r_rom [0:(2**A)-1];
    logic [A-3:0]  r_lut [0:(2**L)-1];

    state_t        r_state;
    logic          r_start_q;
    logic [RW-1:0] w_word;
    logic [2:0]    w_opcode;
    logic          w_is_branch;
    logic          w_is_halt;
    logic          w_par_bad;
    logic          w_launch;
    logic          w_request;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign w_word      = r_rom[pc];
    assign instr       = w_word[W-1:0];
    assign offset      = r_lut[instr[L-1:0]];
    assign w_opcode    = instr[W-1:W-3];
    assign w_is_branch = (w_opcode == 3'b110);
    assign w_is_halt   = (w_opcode == 3'b111) && (&instr[W-4:0]);

`ifdef IFETCH_PARITY_EN
    // Stored parity makes the full word XOR to zero; a one means corruption.
    assign w_par_bad   = ^w_word;
`else
    assign w_par_bad   = 1'b0;
`endif

    assign w_launch  = r_start_q && !start;
    assign w_request = !r_start_q && start;

    // Branch is applied by the PC stage on the next edge, so it must be qualified here.
    assign branch_en = (r_state == S_RUN) && w_is_branch && !w_par_bad;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_start_q   <= 1'b0;
            run         <= 1'b0;
            done        <= 1'b0;
            instr_count <= 16'd0;
`ifdef IFETCH_PARITY_EN
            parity_err  <= 1'b0;
`endif
        end else begin
            r_start_q <= start;
            case (r_state)
                S_IDLE: begin
                    if (w_launch) begin
                        r_state     <= S_RUN;
                        run         <= 1'b1;
                        instr_count <= 16'd0;
                    end
                end
                S_RUN: begin
                    // The terminating instruction (halt or corrupt word) is still retired.
                    instr_count <= sat_inc16(instr_count);
                    if (w_par_bad || w_is_halt) begin
                        r_state <= S_DONE;
                        run     <= 1'b0;
                        done    <= 1'b1;
                    end
`ifdef IFETCH_PARITY_EN
                    if (w_par_bad) begin
                        parity_err <= 1'b1;
                    end
`endif
                end
                S_DONE: begin
                    if (w_request) begin
                        r_state <= S_IDLE;
                        done    <= 1'b0;
`ifdef IFETCH_PARITY_EN
                        parity_err <= 1'b0;
`endif
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    run     <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch_decode.sv
// Self-checking bench for ifetch_decode: directed scenarios plus randomized traffic against
// a rule-level reference model (mode, start history, retired count) kept in plain variables.
module tb_ifetch_decode;
    localparam int A = 10;
    localparam int W = 9;
    localparam int L = 5;
`ifdef IFETCH_PARITY_EN
    localparam int RW = W + 1;
`else
    localparam int RW = W;
`endif

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic [A-1:0]       pc;
    logic [W-1:0]       instr;
    logic               branch_en;
    logic signed [A-3:0] offset;
    logic               run;
    logic               done;
    logic [15:0]        instr_count;
`ifdef IFETCH_PARITY_EN
    logic               parity_err;
`endif

    always #5 clk = ~clk;

    ifetch_decode dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .pc         (pc),
        .instr      (instr),
        .branch_en  (branch_en),
        .offset     (offset),
        .run        (run),
        .done       (done),
        .instr_count(instr_count)
`ifdef IFETCH_PARITY_EN
        ,
        .parity_err (parity_err)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Program image as the bench sees it; m_pflip marks words whose parity bit is corrupted.
    logic [W-1:0]   m_instr [0:(2**A)-1];
    bit             m_pflip [0:(2**A)-1];
    logic [A-3:0]   m_lut   [0:(2**L)-1];

    // Reference model: mode 0=idle, 1=running, 2=finished.
    int m_mode = 0;
    int m_cnt  = 0;
    bit m_sq   = 1'b0;
    bit m_perr = 1'b0;

    function automatic logic [8:0] alu_op();
        return {3'($urandom_range(0, 5)), 6'($urandom)};
    endfunction

    function automatic logic [RW-1:0] rom_word(input int i);
`ifdef IFETCH_PARITY_EN
        return {(^m_instr[i]) ^ m_pflip[i], m_instr[i]};
`else
        return m_instr[i];
`endif
    endfunction

    task automatic load_mem();
        for (int i = 0; i < 2**A; i++) dut.r_rom[i] = rom_word(i);
        for (int i = 0; i < 2**L; i++) dut.r_lut[i] = m_lut[i];
    endtask

    task automatic drive(input logic s, input logic [A-1:0] p);
        start = s;
        pc    = p;
        #1;
    endtask

    // Advance one rising edge and apply the behavioural rules to the model.
    task automatic clock_edge();
        int nmode  = m_mode;
        int ncnt   = m_cnt;
        bit nperr  = m_perr;
        bit launch = m_sq && !start;
        bit req    = !m_sq && start;
        if (reset) begin
            nmode = 0; ncnt = 0; nperr = 1'b0;
        end else if (m_mode == 0) begin
            if (launch) begin nmode = 1; ncnt = 0; end
        end else if (m_mode == 1) begin
            ncnt = (m_cnt == 65535) ? m_cnt : m_cnt + 1;
            if (m_pflip[pc]) begin nperr = 1'b1; nmode = 2; end
            else if (m_instr[pc] == 9'h1FF) nmode = 2;
        end else if (req) begin
            nmode = 0; nperr = 1'b0;
        end
        @(posedge clk);
        m_mode = nmode;
        m_cnt  = ncnt;
        m_perr = nperr;
        m_sq   = reset ? 1'b0 : start;
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        clock_edge();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, '0);
        clock_edge();
        clock_edge();
        reset = 1'b0;
        checks++; if (run !== 1'b0) begin errors++; $display("FAIL reset_run got %b want 0", run); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (instr_count !== 16'd0) begin errors++; $display("FAIL reset_count got %0d want 0", instr_count); end
`ifdef IFETCH_PARITY_EN
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_perr got %b want 0", parity_err); end
`endif
    endtask

    task automatic test_program();
        for (int i = 0; i < 4; i++) m_instr[i] = alu_op();
        m_instr[4] = 9'b111111111;
        load_mem();
        drive(1'b1, '0); clock_edge();
        drive(1'b0, '0); clock_edge();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 10'(i));
            checks++;
            if (run !== 1'b1 || branch_en !== 1'b0 || instr !== m_instr[i]) begin
                errors++;
                $display("FAIL prog_step pc=%0d run=%b br=%b instr=%b want run=1 br=0 instr=%b", i, run, branch_en, instr, m_instr[i]);
            end
            clock_edge();
        end
        checks++; if ({run, done} !== 2'b01) begin errors++; $display("FAIL prog_done run/done=%b%b want 01", run, done); end
        checks++; if (instr_count !== 16'd5) begin errors++; $display("FAIL prog_count got %0d want 5", instr_count); end
    endtask

    task automatic test_branch();
        m_instr[0] = alu_op(); m_instr[1] = alu_op(); m_instr[3] = alu_op();
        m_instr[2] = 9'b110000011;
        m_instr[4] = 9'b111111111;
        m_lut[3]   = 8'hFC;
        load_mem();
        drive(1'b1, '0); clock_edge();
        drive(1'b0, '0); clock_edge();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 10'(i));
            if (i == 2) begin
                checks++; if (branch_en !== 1'b1) begin errors++; $display("FAIL br_taken got %b want 1", branch_en); end
                checks++; if (offset !== 8'hFC) begin errors++; $display("FAIL br_offset got %h want fc", offset); end
            end else begin
                checks++; if (branch_en !== 1'b0) begin errors++; $display("FAIL br_alu pc=%0d got %b want 0", i, branch_en); end
            end
            clock_edge();
        end
        checks++; if (done !== 1'b1 || instr_count !== 16'd5) begin errors++; $display("FAIL br_end done=%b count=%0d want 1/5", done, instr_count); end
    endtask

    task automatic test_idle();
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 10'd2);
            checks++; if (branch_en !== 1'b0) begin errors++; $display("FAIL idle_branch got %b want 0", branch_en); end
            checks++; if (offset !== 8'hFC) begin errors++; $display("FAIL idle_offset got %h want fc", offset); end
            clock_edge();
            checks++; if (instr_count !== 16'd0 || run !== 1'b0) begin errors++; $display("FAIL idle_count count=%0d run=%b want 0/0", instr_count, run); end
        end
        drive(1'b1, 10'd2); clock_edge();
        checks++; if (run !== 1'b0) begin errors++; $display("FAIL idle_request run=%b want 0", run); end
    endtask

    task automatic test_done_request();
        // Starts in idle with start_q=1: dropping start launches.
        bit sv [0:4] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        drive(1'b0, '0); clock_edge();
        for (int i = 0; i < 5; i++) begin
            drive(sv[i], 10'(i));
            clock_edge();
            if (i < 4) begin
                checks++; if (run !== 1'b1) begin errors++; $display("FAIL run_ignores_start pc=%0d run=%b want 1", i, run); end
            end
        end
        checks++; if ({run, done} !== 2'b01 || instr_count !== 16'd5) begin errors++; $display("FAIL halt_wins run/done=%b%b count=%0d want 01/5", run, done, instr_count); end
        drive(1'b0, '0); clock_edge();
        checks++; if (done !== 1'b1 || run !== 1'b0) begin errors++; $display("FAIL done_launch_ignored done=%b run=%b want 1/0", done, run); end
        drive(1'b1, '0); clock_edge();
        checks++; if (done !== 1'b0 || run !== 1'b0) begin errors++; $display("FAIL done_request done=%b run=%b want 0/0", done, run); end
        drive(1'b0, '0); clock_edge();
        checks++; if (run !== 1'b1 || instr_count !== 16'd0) begin errors++; $display("FAIL relaunch run=%b count=%0d want 1/0", run, instr_count); end
        for (int i = 0; i < 5; i++) begin drive(1'b0, 10'(i)); clock_edge(); end
    endtask

    task automatic test_reset_mid_run();
        for (int i = 0; i < 7; i++) m_instr[i] = alu_op();
        m_instr[7] = {3'b110, 6'($urandom)};
        load_mem();
        drive(1'b1, '0); clock_edge();
        drive(1'b0, '0); clock_edge();
        for (int i = 0; i < 7; i++) begin drive(1'b0, 10'(i)); clock_edge(); end
        checks++; if (instr_count !== 16'd7) begin errors++; $display("FAIL mid_count got %0d want 7", instr_count); end
        drive(1'b0, 10'd7);
        checks++; if (branch_en !== 1'b1) begin errors++; $display("FAIL mid_branch got %b want 1", branch_en); end
        apply_reset();
        checks++; if ({run, done} !== 2'b00 || instr_count !== 16'd0) begin errors++; $display("FAIL mid_reset run/done=%b%b count=%0d want 00/0", run, done, instr_count); end
        checks++; if (branch_en !== 1'b0) begin errors++; $display("FAIL mid_reset_branch got %b want 0", branch_en); end
    endtask

`ifdef IFETCH_PARITY_EN
    task automatic test_parity();
        apply_reset();
        m_instr[0] = alu_op();
        m_instr[1] = {3'b110, 6'($urandom)};
        m_instr[2] = alu_op(); m_instr[3] = alu_op();
        m_instr[4] = 9'b111111111;
        m_pflip[1] = 1'b1;
        load_mem();
        drive(1'b1, '0); clock_edge();
        drive(1'b0, '0); clock_edge();
        drive(1'b0, 10'd0); clock_edge();
        drive(1'b0, 10'd1);
        checks++; if (branch_en !== 1'b0) begin errors++; $display("FAIL par_branch got %b want 0", branch_en); end
        clock_edge();
        checks++; if (parity_err !== 1'b1 || done !== 1'b1 || instr_count !== 16'd2) begin errors++; $display("FAIL par_stop perr=%b done=%b count=%0d want 1/1/2", parity_err, done, instr_count); end
        drive(1'b0, 10'd2); clock_edge(); clock_edge();
        checks++; if (parity_err !== 1'b1) begin errors++; $display("FAIL par_sticky got %b want 1", parity_err); end
        drive(1'b1, 10'd2); clock_edge();
        checks++; if (parity_err !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL par_clear perr=%b done=%b want 0/0", parity_err, done); end
        m_pflip[1] = 1'b0;
        load_mem();
    endtask
`endif

    task automatic test_random();
        logic s;
        logic [A-1:0] p;
        logic [2:0] op;
        for (int i = 0; i < 32; i++) begin
            m_instr[i] = ($urandom_range(0, 7) == 0) ? 9'h1FF : 9'($urandom);
`ifdef IFETCH_PARITY_EN
            m_pflip[i] = ($urandom_range(0, 15) == 0);
`endif
        end
        for (int i = 0; i < 2**L; i++) m_lut[i] = 8'($urandom);
        load_mem();
        s = start;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 2) == 0) s = ~s;
            p = 10'($urandom_range(0, 31));
            reset = ($urandom_range(0, 49) == 0);
            drive(s, p);
            op = m_instr[p][W-1:W-3];
            checks++; if (instr !== m_instr[p]) begin errors++; $display("FAIL rnd_instr pc=%0d got %b want %b", p, instr, m_instr[p]); end
            checks++; if (offset !== m_lut[m_instr[p][L-1:0]]) begin errors++; $display("FAIL rnd_offset pc=%0d got %h want %h", p, offset, m_lut[m_instr[p][L-1:0]]); end
            checks++;
            if (branch_en !== ((m_mode == 1) && (op == 3'b110) && !m_pflip[p])) begin
                errors++; $display("FAIL rnd_branch pc=%0d mode=%0d got %b", p, m_mode, branch_en);
            end
            clock_edge();
            checks++;
            if (run !== (m_mode == 1) || done !== (m_mode == 2) || instr_count !== 16'(m_cnt)) begin
                errors++; $display("FAIL rnd_state run=%b done=%b count=%0d want mode=%0d count=%0d", run, done, instr_count, m_mode, m_cnt);
            end
`ifdef IFETCH_PARITY_EN
            checks++; if (parity_err !== m_perr) begin errors++; $display("FAIL rnd_perr got %b want %b", parity_err, m_perr); end
`endif
        end
        reset = 1'b0;
    endtask

    task automatic test_saturation();
        apply_reset();
        for (int i = 0; i < 32; i++) m_pflip[i] = 1'b0;
        m_instr[0] = alu_op();
        load_mem();
        drive(1'b1, '0); clock_edge();
        drive(1'b0, '0); clock_edge();
        for (int n = 0; n < 65534; n++) clock_edge();
        checks++; if (instr_count !== 16'hFFFE) begin errors++; $display("FAIL sat_before got %h want fffe", instr_count); end
        clock_edge();
        checks++; if (instr_count !== 16'hFFFF) begin errors++; $display("FAIL sat_reach got %h want ffff", instr_count); end
        for (int n = 0; n < 3; n++) clock_edge();
        checks++; if (instr_count !== 16'hFFFF || run !== 1'b1) begin errors++; $display("FAIL sat_hold got %h run=%b want ffff/1", instr_count, run); end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        pc    = '0;
        #1;
        for (int i = 0; i < 2**A; i++) begin m_instr[i] = alu_op(); m_pflip[i] = 1'b0; end
        for (int i = 0; i < 2**L; i++) m_lut[i] = 8'($urandom);
        load_mem();
        test_reset();
        test_program();
        test_branch();
        test_idle();
        test_done_request();
        test_reset_mid_run();
`ifdef IFETCH_PARITY_EN
        test_parity();
`endif
        test_random();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
